// File: rtl/pwm_modulator_if.sv
// Duty-value handshake between the product producer and the PWM stage.
// The master drives a duty word with valid; the slave returns ready.
interface pwm_modulator_if #(
    parameter int Width = 16
);
    logic [Width-1:0] duty_i;
    logic             duty_valid_i;
    logic             duty_ready_o;

    modport master (
        output duty_i,
        output duty_valid_i,
        input  duty_ready_o
    );

    modport slave (
        input  duty_i,
        input  duty_valid_i,
        output duty_ready_o
    );
endinterface

// File: rtl/pwm_modulator.sv
// PWM stage: duty updates pass through a one-deep pending register and are
// only applied at period boundaries, so no period is ever partial or glitched.
module pwm_modulator #(
    parameter int Width = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           enable_i,
    pwm_modulator_if.slave duty_if,
    output logic           modulated_o,
    output logic           period_start_o
);

    localparam logic [0:0]       IDLE    = 1'b0;
    localparam logic [0:0]       RUN     = 1'b1;
    localparam logic [Width-1:0] CNT_MAX = {Width{1'b1}};
    localparam logic [Width-1:0] CNT_ONE = {{(Width-1){1'b0}}, 1'b1};
    localparam logic [Width-1:0] CNT_ZERO = {Width{1'b0}};

    logic [0:0]       state_q;
    logic [Width-1:0] cnt_q;
    logic [Width-1:0] active_q;
    logic [Width-1:0] pending_q;
    logic             pending_vld_q;

    logic [0:0]       w_state_d;
    logic [Width-1:0] w_cnt_d;
    logic [Width-1:0] w_active_d;
    logic [Width-1:0] w_pending_d;
    logic             w_pending_vld_d;
    logic             w_period_load;
    logic             w_transfer;
    logic             w_modulated_d;
    logic             w_period_start_d;

    assign duty_if.duty_ready_o = !pending_vld_q;
    assign w_transfer           = duty_if.duty_valid_i && !pending_vld_q;

    // Next-state: run/stop sequencing, counter, period load and handshake.
    always_comb begin
        w_state_d       = state_q;
        w_cnt_d         = cnt_q;
        w_active_d      = active_q;
        w_pending_d     = pending_q;
        w_pending_vld_d = pending_vld_q;
        w_period_load   = 1'b0;

        case (state_q)
            IDLE: begin
                w_cnt_d = CNT_ZERO;
                if (enable_i) begin
                    w_state_d     = RUN;
                    w_period_load = 1'b1;
                end else begin
                    w_state_d = IDLE;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    w_state_d = IDLE;
                    w_cnt_d   = CNT_ZERO;
                end else begin
                    w_cnt_d       = cnt_q + CNT_ONE;
                    w_period_load = (cnt_q == CNT_MAX);
                end
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = CNT_ZERO;
            end
        endcase

        // The load sees the old pending flag, so a same-edge transfer waits a full period.
        if (w_period_load && pending_vld_q) begin
            w_active_d      = pending_q;
            w_pending_vld_d = 1'b0;
        end else begin
            w_active_d = w_active_d;
        end

        if (w_transfer) begin
            w_pending_d     = duty_if.duty_i;
            w_pending_vld_d = 1'b1;
        end else begin
            w_pending_d = w_pending_d;
        end

        w_modulated_d    = (w_state_d == RUN) && (w_cnt_d < w_active_d);
        w_period_start_d = (w_state_d == RUN) && (w_cnt_d == CNT_ZERO);
    end

    // State, counter, duty registers and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= CNT_ZERO;
            active_q       <= CNT_ZERO;
            pending_q      <= CNT_ZERO;
            pending_vld_q  <= 1'b0;
            modulated_o    <= 1'b0;
            period_start_o <= 1'b0;
        end else begin
            state_q        <= w_state_d;
            cnt_q          <= w_cnt_d;
            active_q       <= w_active_d;
            pending_q      <= w_pending_d;
            pending_vld_q  <= w_pending_vld_d;
            modulated_o    <= w_modulated_d;
            period_start_o <= w_period_start_d;
        end
    end

endmodule

// File: tb/tb_pwm_modulator.sv
// Self-checking bench for pwm_modulator using an 8-bit counter (256-cycle period);
// expected high-cycle counts per period are queued as duty values are driven.
module tb_pwm_modulator;

    localparam int W = 8;
    localparam int P = 1 << W;

    logic clk      = 1'b0;
    logic rst_ni   = 1'b0;
    logic enable_i = 1'b0;
    logic modulated_o;
    logic period_start_o;

    int n_checks = 0;
    int n_errors = 0;
    int sb_q[$];

    bit in_per;
    int per_len;
    int per_hi;
    bit seen_low;
    bit glitch;

    always #5 clk = ~clk;

    pwm_modulator_if #(.Width(W)) u_if ();

    pwm_modulator #(.Width(W)) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .duty_if        (u_if),
        .modulated_o    (modulated_o),
        .period_start_o (period_start_o)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic end_period();
        int e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            check_val("hi_cycles", per_hi, e);
            check_val("period_len", per_len, P);
            check_val("high_first", int'(glitch), 0);
        end
    endtask

    // Advance one clock and measure the completed-period waveform.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_ni || !enable_i) begin
            in_per = 1'b0;
        end else begin
            if (period_start_o) begin
                if (in_per) end_period();
                in_per   = 1'b1;
                per_len  = 0;
                per_hi   = 0;
                seen_low = 1'b0;
                glitch   = 1'b0;
            end
            if (in_per) begin
                per_len++;
                if (modulated_o) begin
                    per_hi++;
                    if (seen_low) glitch = 1'b1;
                end else begin
                    seen_low = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_ps(input int n);
        for (int k = 0; k < n; k++) begin
            int c;
            c = 0;
            do begin
                tick();
                c++;
            end while (!period_start_o && c < 2 * P + 4);
            if (!period_start_o) check_val("ps_timeout", int'(period_start_o), 1);
        end
    endtask

    task automatic send_duty(input int v);
        int c;
        c = 0;
        u_if.duty_i       = v[W-1:0];
        u_if.duty_valid_i = 1'b1;
        while (!u_if.duty_ready_o && c < 2 * P + 4) begin
            tick();
            c++;
        end
        check_val("send_ready", int'(u_if.duty_ready_o), 1);
        tick();
        u_if.duty_valid_i = 1'b0;
    endtask

    initial begin
        int d_chain;
        int d_a;
        int d_b;
        int d_c;
        d_chain = 2 * 7;
        d_a     = 81;
        d_b     = 37;
        d_c     = 100;
        u_if.duty_i       = '0;
        u_if.duty_valid_i = 1'b0;

        #1;
        check_val("rst_mod", int'(modulated_o), 0);
        check_val("rst_ps", int'(period_start_o), 0);
        check_val("rst_ready", int'(u_if.duty_ready_o), 1);
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        check_val("idle_mod", int'(modulated_o), 0);
        check_val("idle_ps", int'(period_start_o), 0);

        // Multiplier-chain duty loaded in IDLE, then enabled.
        send_duty(d_chain);
        check_val("ready_fall", int'(u_if.duty_ready_o), 0);
        enable_i = 1'b1;
        tick();
        check_val("en_ps", int'(period_start_o), 1);
        check_val("en_mod", int'(modulated_o), 1);
        check_val("ready_rise", int'(u_if.duty_ready_o), 1);
        sb_q.push_back(d_chain);
        sb_q.push_back(d_chain);
        wait_ps(2);

        // Extremes: zero, near-full, full.
        sb_q.push_back(d_chain);
        sb_q.push_back(0);
        sb_q.push_back(0);
        send_duty(0);
        wait_ps(3);
        sb_q.push_back(0);
        sb_q.push_back(200);
        send_duty(200);
        wait_ps(1);
        sb_q.push_back(P - 1);
        sb_q.push_back(P - 1);
        send_duty(P - 1);
        wait_ps(3);

        // Back-pressure: second write stalls until the boundary.
        sb_q.push_back(P - 1);
        sb_q.push_back(d_a);
        sb_q.push_back(d_b);
        send_duty(d_a);
        u_if.duty_i       = d_b[W-1:0];
        u_if.duty_valid_i = 1'b1;
        tick();
        check_val("bp_stall", int'(u_if.duty_ready_o), 0);
        send_duty(d_b);
        check_val("bp_pending", int'(u_if.duty_ready_o), 0);
        wait_ps(2);

        // Transfer on the exact wrap edge is applied one period later.
        sb_q.push_back(d_b);
        sb_q.push_back(d_b);
        sb_q.push_back(d_c);
        repeat (P - 1) tick();
        u_if.duty_i       = d_c[W-1:0];
        u_if.duty_valid_i = 1'b1;
        tick();
        u_if.duty_valid_i = 1'b0;
        check_val("wrap_ps", int'(period_start_o), 1);
        check_val("wrap_pending", int'(u_if.duty_ready_o), 0);
        wait_ps(2);

        // Enable toggle mid-period with duty 14.
        sb_q.push_back(d_c);
        send_duty(d_chain);
        wait_ps(1);
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 13) check_val("tog_hi_last", int'(modulated_o), 1);
            if (i == 14) check_val("tog_lo_first", int'(modulated_o), 0);
        end
        enable_i = 1'b0;
        tick();
        check_val("dis_mod", int'(modulated_o), 0);
        check_val("dis_ps", int'(period_start_o), 0);
        repeat (3) tick();
        check_val("dis_hold", int'(modulated_o), 0);
        enable_i = 1'b1;
        tick();
        check_val("reen_ps", int'(period_start_o), 1);
        check_val("reen_mod", int'(modulated_o), 1);
        sb_q.push_back(d_chain);
        sb_q.push_back(d_chain);
        wait_ps(2);

        // Asynchronous reset mid-period drops outputs and the pending duty.
        send_duty(50);
        check_val("pre_rst_pending", int'(u_if.duty_ready_o), 0);
        repeat (3) tick();
        check_val("pre_rst_mod", int'(modulated_o), 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_val("arst_mod", int'(modulated_o), 0);
        check_val("arst_ps", int'(period_start_o), 0);
        check_val("arst_ready", int'(u_if.duty_ready_o), 1);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        check_val("post_rst_ps", int'(period_start_o), 1);
        check_val("post_rst_mod", int'(modulated_o), 0);
        sb_q.push_back(0);
        wait_ps(1);
        enable_i = 1'b0;
        tick();
        check_val("sb_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
